// File: rtl/dynamic_sreg_pkg.sv
// Shared constants and helpers for the multi-channel addressable shift register.
// IS_SYNC takes one of the two string constants below. SRL_STYLE_DEF is the
// default storage style attribute. fill_width() gives the fill counter width,
// which must be able to hold the value DEPTH = 2**AW.
package dynamic_sreg_pkg;

  localparam string SYNC_TRUE     = "true";
  localparam string SYNC_FALSE    = "false";
  localparam string SRL_STYLE_DEF = "srl";

  function automatic int fill_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/dynamic_sreg_lane.sv
// One lane of the addressable shift register: DEPTH x DW storage and its tap mux.
// The storage has no reset, so synthesis can map it onto SRL primitives.
// Ports:
//   clk   rising-edge clock
//   ce    shift enable
//   si    sample written into stage 0 on a shift
//   addr  tap select; k reads the sample written k shifts ago
//   so    tap data (combinational)
module dynamic_sreg_lane
  import dynamic_sreg_pkg::*;
#(
  parameter int    AW            = 4,
  parameter int    DW            = 8,
  parameter string SRL_STYLE_VAL = SRL_STYLE_DEF
) (
  input  logic          clk,
  input  logic          ce,
  input  logic [DW-1:0] si,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] so
);

  localparam int DEPTH = 1 << AW;

  (* srl_style = SRL_STYLE_VAL *) logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ce) begin
      mem[0] <= si;
      for (int k = 1; k < DEPTH; k++) begin
        mem[k] <= mem[k-1];
      end
    end
  end

  assign so = mem[addr];

endmodule

// File: rtl/dynamic_sreg_mc.sv
// Multi-channel addressable shift register used as a variable-delay alignment
// buffer. NCH lanes share one shift enable. Each lane has its own read tap, so
// each lane can have its own delay of 1..2**AW shifts.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset; it has priority over ce
//   ce        shift enable, common to all lanes
//   si        serial input, lane c at [c*DW +: DW]
//   addr      per-lane tap, lane c at [c*AW +: AW]
//   so        per-lane tap data (registered when IS_SYNC = "true")
//   so_valid  lane tap holds a sample written since the last reset
//   full      DEPTH samples have been shifted in since reset
module dynamic_sreg_mc
  import dynamic_sreg_pkg::*;
#(
  parameter int    AW            = 4,
  parameter int    DW            = 8,
  parameter int    NCH           = 2,
  parameter string IS_SYNC       = SYNC_FALSE,
  parameter string SRL_STYLE_VAL = SRL_STYLE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [NCH*DW-1:0] si,
  input  logic [NCH*AW-1:0] addr,
  output logic [NCH*DW-1:0] so,
  output logic [NCH-1:0]    so_valid,
  output logic              full
);

  localparam int             DEPTH   = 1 << AW;
  localparam int             FW      = fill_width(AW);
  localparam logic [FW-1:0]  DEPTH_F = FW'(DEPTH);

  logic [FW-1:0]     fill;
  logic [NCH*DW-1:0] so_c;
  logic [NCH-1:0]    valid_c;

  // fill counts shifts since reset and stops at DEPTH. Once the buffer is
  // full, later shifts only drop the oldest sample, so every tap stays valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill <= '0;
    end else if (ce && (fill != DEPTH_F)) begin
      fill <= fill + FW'(1);
    end
  end

  assign full = (fill == DEPTH_F);

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    dynamic_sreg_lane #(
      .AW            (AW),
      .DW            (DW),
      .SRL_STYLE_VAL (SRL_STYLE_VAL)
    ) u_lane (
      .clk  (clk),
      .ce   (ce),
      .si   (si[c*DW +: DW]),
      .addr (addr[c*AW +: AW]),
      .so   (so_c[c*DW +: DW])
    );

    // Tap k holds real data once more than k samples have been shifted in.
    assign valid_c[c] = (fill > {1'b0, addr[c*AW +: AW]});
  end

  if (IS_SYNC == SYNC_TRUE) begin : g_sync
    // The output register samples every cycle, independent of ce, so a change
    // of addr shows up one edge later even while the data is held.
    always_ff @(posedge clk) begin
      if (rst) begin
        so       <= '0;
        so_valid <= '0;
      end else begin
        so       <= so_c;
        so_valid <= valid_c;
      end
    end
  end else begin : g_async
    assign so       = so_c;
    assign so_valid = valid_c;
  end

endmodule
